cla_mp_sequencer: RTL and testbench

- Sequences one shared 16-bit carry-lookahead adder to perform multi-word add/subtract on WORDS×W-bit operands, one slice per cycle, with the ripple carry registered between slices.
- Arbitrates the adder round-robin between two requesters.
- Returns the full result with carry-out and signed overflow.
- The adder instance is external: this block drives its A/B/Cin and consumes its S/Cout.

---
 rtl/cla_mp_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_cla_mp_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/cla_mp_sequencer.sv
// Multi-word add/subtract sequencer driving one shared external W-bit adder,
// one slice per cycle, with a round-robin arbiter between two requesters.
module cla_mp_sequencer #(
    parameter int W     = 16,
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_valid,
    input  logic [1:0]           req_sub,
    input  logic [W*WORDS-1:0]   req0_a,
    input  logic [W*WORDS-1:0]   req0_b,
    input  logic [W*WORDS-1:0]   req1_a,
    input  logic [W*WORDS-1:0]   req1_b,
    output logic [1:0]           req_ready,
    output logic [W-1:0]         add_a,
    output logic [W-1:0]         add_b,
    output logic                 add_cin,
    input  logic [W-1:0]         add_s,
    input  logic                 add_cout,
    output logic [W*WORDS-1:0]   res,
    output logic                 res_cout,
    output logic                 res_ovf,
    output logic                 res_id,
    output logic                 res_valid,
    output logic                 busy
);
    localparam int N  = W * WORDS;
    localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_next_s;
    logic [N-1:0]  a_r;
    logic [N-1:0]  bx_r;
    logic [N-1:0]  res_r;
    logic [KW-1:0] k_r;
    logic          carry_r;
    logic          last_grant_r;
    logic          res_cout_r;
    logic          res_ovf_r;
    logic          res_id_r;
    logic          winner_s;
    logic          win_sub_s;
    logic          accept_s;
    logic [N-1:0]  win_a_s;
    logic [N-1:0]  win_b_s;

    // Winner selection: a tie goes to the requester that did not win last time
    always_comb begin
        winner_s = 1'b0;
        case (req_valid)
            2'b01:   winner_s = 1'b0;
            2'b10:   winner_s = 1'b1;
            2'b11:   winner_s = ~last_grant_r;
            default: winner_s = 1'b0;
        endcase
    end

    assign accept_s  = (state_r == IDLE) && (req_valid != 2'b00);
    assign win_sub_s = req_sub[winner_s];
    assign win_a_s   = winner_s ? req1_a : req0_a;
    assign win_b_s   = winner_s ? req1_b : req0_b;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (k_r == K_LAST) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Operand latch, slice counter, ripple carry and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r          <= '0;
            bx_r         <= '0;
            res_r        <= '0;
            k_r          <= '0;
            carry_r      <= 1'b0;
            last_grant_r <= 1'b1;
            res_cout_r   <= 1'b0;
            res_ovf_r    <= 1'b0;
            res_id_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_r          <= win_a_s;
                        bx_r         <= win_b_s ^ {N{win_sub_s}};
                        carry_r      <= win_sub_s;
                        k_r          <= '0;
                        last_grant_r <= winner_s;
                        res_id_r     <= winner_s;
                    end
                end
                RUN: begin
                    res_r[k_r*W +: W] <= add_s;
                    carry_r           <= add_cout;
                    if (k_r == K_LAST) begin
                        k_r        <= '0;
                        res_cout_r <= add_cout;
                        // Same-sign operands producing a different-sign sum
                        res_ovf_r  <= (a_r[N-1] == bx_r[N-1]) && (add_s[W-1] != a_r[N-1]);
                    end else begin
                        k_r <= k_r + KW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode from state; req_ready is masked while reset is held
    always_comb begin
        req_ready = 2'b00;
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s && !rst) begin
                    req_ready[winner_s] = 1'b1;
                end else begin
                    req_ready = 2'b00;
                end
            end
            RUN: begin
                add_a   = a_r[k_r*W +: W];
                add_b   = bx_r[k_r*W +: W];
                add_cin = carry_r;
                busy    = 1'b1;
            end
            DONE: begin
                res_valid = 1'b1;
                busy      = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign res      = res_r;
    assign res_cout = res_cout_r;
    assign res_ovf  = res_ovf_r;
    assign res_id   = res_id_r;

endmodule

// File: tb/tb_cla_mp_sequencer.sv
// Randomized self-checking bench for cla_mp_sequencer with a behavioural
// 64-bit arithmetic model and a combinational 16-bit adder in place of the CLA.
module tb_cla_mp_sequencer;
    localparam int W     = 16;
    localparam int WORDS = 4;
    localparam int N     = W * WORDS;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req_valid;
    logic [1:0]    req_sub;
    logic [N-1:0]  req0_a, req0_b, req1_a, req1_b;
    logic [1:0]    req_ready;
    logic [W-1:0]  add_a, add_b, add_s;
    logic          add_cin, add_cout;
    logic [N-1:0]  res;
    logic          res_cout, res_ovf, res_id, res_valid, busy;

    int n_checks = 0;
    int n_errors = 0;

    cla_mp_sequencer #(.W(W), .WORDS(WORDS)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_sub(req_sub),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req_ready(req_ready),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout),
        .res(res), .res_cout(res_cout), .res_ovf(res_ovf), .res_id(res_id),
        .res_valid(res_valid), .busy(busy)
    );

    // Stand-in for the external carry-lookahead adder
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference result: {ovf, cout, res} from whole-number arithmetic
    function automatic logic [65:0] ref_op(input bit sub, input logic [63:0] a, input logic [63:0] b);
        logic signed [65:0] sa, sb, t;
        logic [64:0]        u;
        logic               cout, ovf;
        sa = $signed({{2{a[63]}}, a});
        sb = $signed({{2{b[63]}}, b});
        t  = sub ? (sa - sb) : (sa + sb);
        ovf = (t[65:63] != 3'b000) && (t[65:63] != 3'b111);
        u = {1'b0, a} + {1'b0, b};
        cout = sub ? (a >= b) : u[64];
        return {ovf, cout, sub ? (a - b) : (a + b)};
    endfunction

    // Carry entering slice s: carry (add) or no-borrow (sub) out of the lower bits
    function automatic logic carry_in(input bit sub, input logic [63:0] a, input logic [63:0] b, input int s);
        logic [64:0] m, la, lb;
        m  = (65'd1 << (16 * s)) - 65'd1;
        la = {1'b0, a} & m;
        lb = {1'b0, b} & m;
        if (sub) return la >= lb;
        return ((la + lb) >> (16 * s)) != 65'd0;
    endfunction

    task automatic wait_ready();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready != 2'b00) break;
        end
    endtask

    task automatic run_op(input int id, input bit sub, input logic [63:0] a, input logic [63:0] b,
                          input bit perturb);
        logic [65:0] exp;
        logic [63:0] bx;
        exp = ref_op(sub, a, b);
        bx  = sub ? ~b : b;
        req_valid = 2'b00;
        req_valid[id] = 1'b1;
        req_sub[id]   = sub;
        if (id == 0) begin req0_a = a; req0_b = b; end
        else         begin req1_a = a; req1_b = b; end
        wait_ready();
        check("req_ready", {62'd0, req_ready}, (id == 0) ? 64'd1 : 64'd2);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        if (perturb) begin
            req_sub[id] = ~sub;
            if (id == 0) begin req0_a = {$urandom(), $urandom()}; req0_b = {$urandom(), $urandom()}; end
            else         begin req1_a = {$urandom(), $urandom()}; req1_b = {$urandom(), $urandom()}; end
        end
        for (int s = 0; s < WORDS; s++) begin
            @(negedge clk);
            check("run_busy", {63'd0, busy}, 64'd1);
            check("run_nvalid", {63'd0, res_valid}, 64'd0);
            check("slice_a", {48'd0, add_a}, (a >> (16 * s)) & 64'hFFFF);
            check("slice_b", {48'd0, add_b}, (bx >> (16 * s)) & 64'hFFFF);
            check("slice_cin", {63'd0, add_cin}, {63'd0, carry_in(sub, a, b, s)});
        end
        @(negedge clk);
        check("res_valid", {63'd0, res_valid}, 64'd1);
        check("res", res, exp[63:0]);
        check("res_cout", {63'd0, res_cout}, {63'd0, exp[64]});
        check("res_ovf", {63'd0, res_ovf}, {63'd0, exp[65]});
        check("res_id", {63'd0, res_id}, id);
        @(negedge clk);
        check("valid_one_cycle", {63'd0, res_valid}, 64'd0);
        check("idle_busy", {63'd0, busy}, 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out"}, {res_cout, res_ovf, res_id, res_valid, busy, add_cin, req_ready,
                              add_a, add_b}, 64'd0);
        check({tag, "_res"}, res, 64'd0);
    endtask

    initial begin
        int grants, results, prev_cyc, exp_id, dropped;
        int q_id[$];
        logic [65:0] exp0, exp1, e;

        rst = 1'b1;
        req_valid = 2'b00;
        req_sub = 2'b00;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        #1;
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        run_op(0, 1'b0, 64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
        run_op(0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        run_op(1, 1'b1, 64'd5, 64'd7, 1'b0);
        run_op(1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        run_op(0, 1'b1, 64'h8000_0000_0000_0000, 64'h1, 1'b0);
        run_op(1, 1'b1, 64'h1234, 64'h1234, 1'b0);
        run_op(0, 1'b0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1);

        for (int i = 0; i < 16; i++) begin
            run_op(int'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                   {$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b1);
        end

        // Both requesters held valid from reset: strict alternation, 6-cycle spacing
        rst = 1'b1;
        req0_a = {$urandom(), $urandom()}; req0_b = {$urandom(), $urandom()};
        req1_a = {$urandom(), $urandom()}; req1_b = {$urandom(), $urandom()};
        req_sub = 2'b10;
        exp0 = ref_op(1'b0, req0_a, req0_b);
        exp1 = ref_op(1'b1, req1_a, req1_b);
        req_valid = 2'b11;
        @(posedge clk); #1;
        rst = 1'b0;
        grants = 0; results = 0; prev_cyc = -1; dropped = 0;
        for (int cyc = 0; cyc < 60 && results < 4; cyc++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                exp_id = grants % 2;
                check("rr_grant", {62'd0, req_ready}, (exp_id == 0) ? 64'd1 : 64'd2);
                if (prev_cyc >= 0) check("rr_gap", cyc - prev_cyc, 64'd6);
                prev_cyc = cyc;
                q_id.push_back(exp_id);
                grants++;
            end
            if (res_valid) begin
                if (q_id.size() == 0) begin
                    check("rr_unexpected_valid", {63'd0, res_valid}, 64'd0);
                end else begin
                    exp_id = q_id.pop_front();
                    e = (exp_id == 0) ? exp0 : exp1;
                    check("rr_res_id", {63'd0, res_id}, exp_id);
                    check("rr_res", res, e[63:0]);
                    check("rr_flags", {62'd0, res_ovf, res_cout}, {62'd0, e[65:64]});
                    results++;
                end
            end
            if (grants == 4 && dropped == 0) begin
                @(posedge clk); #1;
                req_valid = 2'b00;
                dropped = 1;
            end
        end
        check("rr_results", results, 64'd4);
        check("rr_grants", grants, 64'd4);

        // Reset during slice 2 aborts the operation; pending request is retaken
        req_valid = 2'b00;
        @(negedge clk);
        req0_a = 64'hFFFF_FFFF_FFFF_FFFF; req0_b = 64'h2;
        req_sub[0] = 1'b0;
        req_valid = 2'b01;
        wait_ready();
        check("abort_ready", {62'd0, req_ready}, 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_all_zero("abort");
        @(posedge clk); #1;
        check_all_zero("abort_hold");
        rst = 1'b0;
        run_op(0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
